// File: rtl/sram_mp_pkg.sv
// Shared types and helpers for the multi-port SRAM front end.
package sram_mp_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEF_NUM_PORTS = 2;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned BYTES         = DEF_DATA_W / BYTE_W;
  localparam int unsigned PORT_IDX_W    = 8;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [PORT_IDX_W-1:0] port_idx;
    logic                  is_read;
  } resp_t;

  // 33-bit compare so a window ending at the top of the address space does not wrap.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] size_bytes);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + size_bytes));
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter: first requester after the last-granted index wins.
module sram_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt     = '0;
    gnt_idx = ptr_q;
    cand    = 0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!found && rst_ni && req[IDX_W'(cand)]) begin
        gnt[IDX_W'(cand)] = 1'b1;
        gnt_idx           = IDX_W'(cand);
        found             = 1'b1;
      end
    end
  end

  // Pointer starts at the last port so port 0 has first priority out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(N - 1);
    end else if (accept) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/sram_mp_wrap.sv
// N-port OBI-style front end onto a single-port word SRAM with round-robin arbitration.
module sram_mp_wrap
  import sram_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned DATA_W    = BYTES * BYTE_W,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_PORTS-1:0]               req_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  input  logic [NUM_PORTS-1:0][31:0]         addr_i,
  input  logic [NUM_PORTS-1:0]               we_i,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]               rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]               err_o,
  output logic                               illegal_memory_o
);

  localparam int unsigned BE_W   = DATA_W / BYTE_W;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [32:0] SIZE_B = 33'(DEPTH * BE_W);

  logic                 accept;
  logic [IDX_W-1:0]     sel;
  logic [31:0]          s_addr;
  logic [31:0]          s_off;
  logic                 s_we;
  logic [BE_W-1:0]      s_be;
  logic [DATA_W-1:0]    s_wdata;
  logic                 s_in_range;
  logic [AW-1:0]        widx;

  logic [DATA_W-1:0]    mem [DEPTH];
  resp_t                resp_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 illegal_q;

  sram_rr_arbiter #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_i),
    .accept  (accept),
    .gnt     (gnt_o),
    .gnt_idx (sel)
  );

  assign accept     = |(req_i & gnt_o);
  assign s_addr     = addr_i[sel];
  assign s_we       = we_i[sel];
  assign s_be       = be_i[sel];
  assign s_wdata    = wdata_i[sel];
  assign s_off      = s_addr - BASE_ADDR;
  assign widx       = AW'(s_off >> OFF_W);
  assign s_in_range = in_range(s_addr, BASE_ADDR, SIZE_B);

  // Array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (accept && s_we && s_in_range) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (s_be[b]) mem[widx][b*BYTE_W +: BYTE_W] <= s_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_q    <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      resp_q.valid    <= accept;
      resp_q.err      <= accept && !s_in_range;
      resp_q.port_idx <= PORT_IDX_W'(sel);
      resp_q.is_read  <= accept && !s_we;
      rdata_q         <= (accept && !s_we && s_in_range) ? mem[widx] : '0;
      if (accept && !s_in_range) illegal_q <= 1'b1;
    end
  end

  // Response is steered to its owner; reset in the response cycle suppresses it.
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (rst_ni && resp_q.valid && (resp_q.port_idx == PORT_IDX_W'(p))) begin
        rvalid_o[p] = 1'b1;
        err_o[p]    = resp_q.err;
        rdata_o[p]  = (resp_q.is_read && !resp_q.err) ? rdata_q : '0;
      end
    end
  end

  assign illegal_memory_o = illegal_q;

endmodule

// File: tb/tb_sram_mp_wrap.sv
// Scoreboard bench for sram_mp_wrap: 2-port/32-bit main instance plus a 4-port/64-bit instance.
module tb_sram_mp_wrap;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        req, gnt, we, rvalid, err;
  logic [1:0][31:0]  addr, wdata, rdata;
  logic [1:0][3:0]   be;
  logic              illegal;

  logic [3:0]        req4, gnt4, we4, rvalid4, err4;
  logic [3:0][31:0]  addr4;
  logic [3:0][7:0]   be4;
  logic [3:0][63:0]  wdata4, rdata4;
  logic              illegal4;

  sram_mp_wrap #(.NUM_PORTS(2), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .illegal_memory_o(illegal)
  );

  sram_mp_wrap #(.NUM_PORTS(4), .DATA_W(64), .DEPTH(256), .BASE_ADDR(32'h0)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req4), .gnt_o(gnt4), .addr_i(addr4), .we_i(we4),
    .be_i(be4), .wdata_i(wdata4), .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4),
    .illegal_memory_o(illegal4)
  );

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  exp_t        sb[$];
  logic [31:0] mdl [256];

  // Pop/compare responses, flag overdue ones, then record newly accepted requests.
  always @(negedge clk) begin : scoreboard
    exp_t e;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (rvalid[p]) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL resp_unexpected: port %0d got rvalid=1, required no response", p);
        end else begin
          e = sb.pop_front();
          if (e.port != p || err[p] !== e.err || rdata[p] !== e.rdata) begin
            n_miss++;
            $display("FAIL resp: got port=%0d err=%b rdata=%h, required port=%0d err=%b rdata=%h",
                     p, err[p], rdata[p], e.port, e.err, e.rdata);
          end
        end
      end
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      n_vec++;
      n_miss++;
      $display("FAIL resp_missing: port %0d got no rvalid, required rvalid=1", sb[0].port);
      sb.delete(0);
    end
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (gnt[p] && req[p]) begin
          e.port = p;
          e.due  = cyc + 1;
          if (addr[p] >= 32'h400) begin
            e.err   = 1'b1;
            e.rdata = '0;
          end else begin
            e.err = 1'b0;
            if (we[p]) begin
              for (int b = 0; b < 4; b++)
                if (be[p][b]) mdl[addr[p][9:2]][b*8 +: 8] = wdata[p][b*8 +: 8];
              e.rdata = '0;
            end else begin
              e.rdata = mdl[addr[p][9:2]];
            end
          end
          sb.push_back(e);
        end
      end
    end
  end

  task automatic access(input int p, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int waits);
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
    waits = 0;
    while (waits <= 20) begin
      @(negedge clk);
      if (gnt[p]) break;
      waits++;
    end
    if (waits > 20) begin
      n_vec++; n_miss++;
      $display("FAIL grant_timeout: port %0d got no gnt, required gnt", p);
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b11; we = '0; addr = '0; be = '0; wdata = '0;
    req4 = '0; we4 = '0; addr4 = '0; be4 = '0; wdata4 = '0;
    step(2);
    @(negedge clk);
    n_vec++; if (gnt !== 2'b00) begin n_miss++; $display("FAIL reset_gnt: got %b, required 00", gnt); end
    n_vec++; if (rvalid !== 2'b00 || err !== 2'b00) begin n_miss++; $display("FAIL reset_rvalid: got rvalid=%b err=%b, required 00/00", rvalid, err); end
    n_vec++; if (rdata !== 64'h0) begin n_miss++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    n_vec++; if (illegal !== 1'b0 || illegal4 !== 1'b0) begin n_miss++; $display("FAIL reset_illegal: got %b/%b, required 0/0", illegal, illegal4); end
    n_vec++; if (rvalid4 !== 4'h0) begin n_miss++; $display("FAIL reset_rvalid4: got %b, required 0000", rvalid4); end
    req = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rr();
    logic [1:0] ex;
    req = 2'b11; we = 2'b11; be = {4'hF, 4'hF};
    addr[0] = 32'h40; wdata[0] = 32'h0A0A_0A0A;
    addr[1] = 32'h44; wdata[1] = 32'h0B0B_0B0B;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ex = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_vec++;
      if (gnt !== ex) begin n_miss++; $display("FAIL rr_order[%0d]: got gnt=%b, required %b", k, gnt, ex); end
    end
    @(posedge clk); #1;
    req = 2'b00;
    step(2);
  endtask

  task automatic test_basic();
    int w;
    access(0, 1'b1, 32'hC, 4'hF, 32'd69, w);
    n_vec++; if (w != 0) begin n_miss++; $display("FAIL basic_wr_gnt_wait: got %0d, required 0", w); end
    access(0, 1'b0, 32'hC, 4'hF, 32'h0, w);
    n_vec++; if (w != 0) begin n_miss++; $display("FAIL basic_rd_gnt_wait: got %0d, required 0", w); end
    @(negedge clk);
    n_vec++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'd69 || err[0] !== 1'b0) begin
      n_miss++; $display("FAIL basic_rd: got rvalid=%b rdata=%h err=%b, required 1/45/0", rvalid[0], rdata[0], err[0]);
    end
    step(1);
  endtask

  task automatic test_bytes();
    int w;
    access(0, 1'b1, 32'h10, 4'hF, 32'hAABB_CCDD, w);
    access(0, 1'b1, 32'h10, 4'b0010, 32'h0000_1100, w);
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, w);
    @(negedge clk);
    n_vec++; if (rdata[0] !== 32'hAABB_11DD) begin n_miss++; $display("FAIL byte_merge: got %h, required aabb11dd", rdata[0]); end
    step(1);
    access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, w);
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, w);
    @(negedge clk);
    n_vec++; if (rdata[0] !== 32'hAABB_11DD) begin n_miss++; $display("FAIL be_zero_noop: got %h, required aabb11dd", rdata[0]); end
    step(1);
  endtask

  task automatic test_oor();
    int w;
    access(0, 1'b1, 32'h0, 4'hF, 32'h1234_5678, w);
    access(0, 1'b1, 32'h3FC, 4'hF, 32'hCAFE_F00D, w);
    access(0, 1'b0, 32'h3FF, 4'hF, 32'h0, w);
    @(negedge clk);
    n_vec++; if (rdata[0] !== 32'hCAFE_F00D || err[0] !== 1'b0) begin n_miss++; $display("FAIL last_word: got rdata=%h err=%b, required cafef00d/0", rdata[0], err[0]); end
    n_vec++; if (illegal !== 1'b0) begin n_miss++; $display("FAIL illegal_early: got %b, required 0", illegal); end
    step(1);
    access(1, 1'b0, 32'h400, 4'hF, 32'h0, w);
    @(negedge clk);
    n_vec++;
    if (rvalid !== 2'b10 || err[1] !== 1'b1 || rdata[1] !== 32'h0) begin
      n_miss++; $display("FAIL oor_resp: got rvalid=%b err1=%b rdata1=%h, required 10/1/0", rvalid, err[1], rdata[1]);
    end
    step(1);
    access(1, 1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF, w);
    access(0, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, w);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++; if (illegal !== 1'b1) begin n_miss++; $display("FAIL illegal_sticky[%0d]: got %b, required 1", k, illegal); end
    end
    step(1);
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, w);
    @(negedge clk);
    n_vec++; if (rdata[0] !== 32'h1234_5678) begin n_miss++; $display("FAIL word0_intact: got %h, required 12345678", rdata[0]); end
    step(1);
  endtask

  task automatic test_raw();
    int w;
    access(1, 1'b1, 32'h20, 4'hF, 32'h55, w);
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, w);
    n_vec++; if (w != 0) begin n_miss++; $display("FAIL raw_gnt_wait: got %0d, required 0", w); end
    @(negedge clk);
    n_vec++; if (rdata[0] !== 32'h55) begin n_miss++; $display("FAIL raw_cross: got %h, required 55", rdata[0]); end
    step(1);
    access(0, 1'b1, 32'h24, 4'hF, 32'h77, w);
    access(0, 1'b0, 32'h24, 4'hF, 32'h0, w);
    @(negedge clk);
    n_vec++; if (rdata[0] !== 32'h77) begin n_miss++; $display("FAIL raw_same: got %h, required 77", rdata[0]); end
    step(1);
  endtask

  task automatic test_reset_mid();
    int w;
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, w);
    rst_n = 1'b0;
    sb.delete();
    req = 2'b11; we = 2'b00; addr[0] = 32'h20; addr[1] = 32'h24;
    @(negedge clk);
    n_vec++; if (rvalid !== 2'b00) begin n_miss++; $display("FAIL rst_suppress: got rvalid=%b, required 00", rvalid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (rvalid !== 2'b00 || gnt !== 2'b00) begin n_miss++; $display("FAIL rst_hold: got rvalid=%b gnt=%b, required 00/00", rvalid, gnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (gnt !== 2'b01) begin n_miss++; $display("FAIL rst_ptr_first: got gnt=%b, required 01", gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (gnt !== 2'b10) begin n_miss++; $display("FAIL rst_ptr_second: got gnt=%b, required 10", gnt); end
    @(posedge clk); #1;
    req = 2'b00;
    step(2);
  endtask

  task automatic test_dut4();
    logic [3:0] ex;
    req4 = 4'hF; we4 = '0; be4 = '0;
    for (int p = 0; p < 4; p++) addr4[p] = 32'h8 * p;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ex = 4'(1) << k;
      n_vec++; if (gnt4 !== ex) begin n_miss++; $display("FAIL rr4_order[%0d]: got gnt=%b, required %b", k, gnt4, ex); end
      if (k > 0) begin
        ex = 4'(1) << (k - 1);
        n_vec++; if (rvalid4 !== ex) begin n_miss++; $display("FAIL rr4_rvalid[%0d]: got %b, required %b", k, rvalid4, ex); end
      end
      @(posedge clk); #1;
    end
    req4 = '0;
    @(negedge clk);
    n_vec++; if (rvalid4 !== 4'b1000) begin n_miss++; $display("FAIL rr4_rvalid_last: got %b, required 1000", rvalid4); end
    @(posedge clk); #1;
    req4[1] = 1'b1; we4[1] = 1'b1; addr4[1] = 32'h20; be4[1] = 8'hFF; wdata4[1] = 64'h55;
    @(negedge clk);
    n_vec++; if (gnt4 !== 4'b0010) begin n_miss++; $display("FAIL raw4_wr_gnt: got %b, required 0010", gnt4); end
    @(posedge clk); #1;
    req4[1] = 1'b0;
    req4[0] = 1'b1; we4[0] = 1'b0; addr4[0] = 32'h20;
    @(negedge clk);
    n_vec++; if (gnt4 !== 4'b0001) begin n_miss++; $display("FAIL raw4_rd_gnt: got %b, required 0001", gnt4); end
    n_vec++; if (rvalid4 !== 4'b0010 || rdata4[1] !== 64'h0) begin n_miss++; $display("FAIL raw4_wr_resp: got rvalid=%b rdata1=%h, required 0010/0", rvalid4, rdata4[1]); end
    @(posedge clk); #1;
    req4[0] = 1'b0;
    req4[3] = 1'b1; we4[3] = 1'b0; addr4[3] = 32'h800;
    @(negedge clk);
    n_vec++; if (rvalid4 !== 4'b0001 || rdata4[0] !== 64'h55) begin n_miss++; $display("FAIL raw4_rd: got rvalid=%b rdata0=%h, required 0001/55", rvalid4, rdata4[0]); end
    @(posedge clk); #1;
    req4[3] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rvalid4 !== 4'b1000 || err4 !== 4'b1000 || rdata4[3] !== 64'h0 || illegal4 !== 1'b1) begin
      n_miss++; $display("FAIL oor4: got rvalid=%b err=%b rdata3=%h illegal=%b, required 1000/1000/0/1", rvalid4, err4, rdata4[3], illegal4);
    end
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr();
    test_basic();
    test_bytes();
    test_oor();
    test_raw();
    test_reset_mid();
    test_dut4();
    step(3);
    n_vec++;
    if (sb.size() != 0) begin n_miss++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
